// File: rtl/ctrl_stream_pkg.sv
// Shared definitions for the result streaming path of the control system.
//   state_e        : streamer FSM states (IDLE, RUN, DONE)
//   DATA_W_DEFAULT : default result word width; upper/lower 32-bit halves
//                    feed the up/down control FIFOs
//   count_t        : 32-bit sample counter type used on the control interface
package ctrl_stream_pkg;

    localparam int DATA_W_DEFAULT = 64;
    localparam int COUNT_W        = 32;

    typedef logic [COUNT_W-1:0] count_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/stream_fifo.sv
// Single-clock synchronous FIFO buffering result words between the
// processing logic and the output register of result_streamer.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear_i      : synchronous flush (pointers and occupancy to zero)
//   push_i       : write push_data_i (ignored while full)
//   pop_i        : advance the read pointer (ignored while empty)
//   pop_data_o   : word at the head of the FIFO, valid while !empty_o
//   full_o       : occupancy == DEPTH
//   empty_o      : occupancy == 0
module stream_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] pop_data_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              push_ok, pop_ok;

    // Flags come straight from the registered occupancy, so a simultaneous
    // push and pop leaves both of them untouched.
    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign push_ok    = push_i && !full_o;
    assign pop_ok     = pop_i && !empty_o;
    assign pop_data_o = mem[rd_ptr_q];

    // NOTE: every variable gets its default before any branch; otherwise a
    // path that skips an assignment makes synthesis infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are exactly AW bits wide, so they wrap modulo DEPTH.
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; its contents are only observable
    // after a push, and leaving it unreset lets it map onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/result_streamer.sv
// Streams a fixed number of result words from the processing logic into the
// control system FIFOs through an internal buffer and an output register.
//   clk, reset_n         : clock, asynchronous active-low reset
//   enable               : run request; low during a run aborts it
//   reset_from_control   : synchronous clear, same effect as reset_n
//   n_samples            : words per run, latched when a run starts
//   in_data/in_valid/in_ready : input handshake (transfer on valid & ready)
//   fifo_almost_full     : downstream cannot take words; stalls popping only
//   result_64_bit        : transmitted word, holds between pulses
//   result_64_bit_valid  : one-cycle write strobe to the control FIFOs
//   calculo_finalizado   : high while the run is complete (DONE)
//   sample_count         : pulses sent in the current or last run
module result_streamer
    import ctrl_stream_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              reset_from_control,
    input  count_t            n_samples,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              fifo_almost_full,
    output logic [DATA_W-1:0] result_64_bit,
    output logic              result_64_bit_valid,
    output logic              calculo_finalizado,
    output count_t            sample_count
);

    state_e            state_q, state_d;
    count_t            n_latched_q, n_latched_d;
    count_t            accepted_q, accepted_d;
    count_t            sample_count_q, sample_count_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              valid_q, valid_d;

    logic              push, pop, fifo_clear;
    logic              fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_rd_data;

    // Built only from registers, so upstream sees a glitch-free ready.
    assign in_ready = (state_q == RUN) && !fifo_full && (accepted_q < n_latched_q);
    assign push     = in_valid && in_ready;

    // No pop on an abort or a control clear: that is what suppresses the
    // valid pulse that would otherwise follow.
    assign pop = (state_q == RUN) && enable && !reset_from_control
                 && !fifo_empty && !fifo_almost_full;

    assign fifo_clear = reset_from_control || ((state_q == RUN) && !enable);

    stream_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear_i     (fifo_clear),
        .push_i      (push),
        .push_data_i (in_data),
        .pop_i       (pop),
        .pop_data_o  (fifo_rd_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        state_d        = state_q;
        n_latched_d    = n_latched_q;
        accepted_d     = push ? accepted_q + count_t'(1) : accepted_q;
        sample_count_d = (valid_q && (sample_count_q < n_latched_q))
                         ? sample_count_q + count_t'(1) : sample_count_q;
        result_d       = pop ? fifo_rd_data : result_q;
        valid_d        = pop;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    n_latched_d    = n_samples;
                    accepted_d     = '0;
                    sample_count_d = '0;
                    state_d        = (n_samples != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (valid_q && (sample_count_q + count_t'(1) == n_latched_q)) begin
                    // The pulse on the output now is the last one of the run.
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!enable) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Control clear overrides every other update in the cycle.
        if (reset_from_control) begin
            state_d        = IDLE;
            n_latched_d    = '0;
            accepted_d     = '0;
            sample_count_d = '0;
            result_d       = '0;
            valid_d        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            n_latched_q    <= '0;
            accepted_q     <= '0;
            sample_count_q <= '0;
            result_q       <= '0;
            valid_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            n_latched_q    <= n_latched_d;
            accepted_q     <= accepted_d;
            sample_count_q <= sample_count_d;
            result_q       <= result_d;
            valid_q        <= valid_d;
        end
    end

    assign result_64_bit       = result_q;
    assign result_64_bit_valid = valid_q;
    assign calculo_finalizado  = (state_q == DONE);
    assign sample_count        = sample_count_q;

endmodule

// File: tb/tb_result_streamer.sv
// Self-checking bench for result_streamer: a queue-based behavioural model
// is compared against the DUT outputs on every falling edge, and directed
// scenarios pin the model with hand-computed expectations.
module tb_result_streamer;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              enable;
    logic              reset_from_control;
    logic [31:0]       n_samples;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              fifo_almost_full;
    logic [DATA_W-1:0] result_64_bit;
    logic              result_64_bit_valid;
    logic              calculo_finalizado;
    logic [31:0]       sample_count;

    int errors = 0;
    int checks = 0;

    result_streamer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .enable              (enable),
        .reset_from_control  (reset_from_control),
        .n_samples           (n_samples),
        .in_data             (in_data),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .fifo_almost_full    (fifo_almost_full),
        .result_64_bit       (result_64_bit),
        .result_64_bit_valid (result_64_bit_valid),
        .calculo_finalizado  (calculo_finalizado),
        .sample_count        (sample_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, actual, expected);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_run, m_fin, m_vout;
    logic [63:0] m_rout;
    int unsigned m_n, m_acc, m_sent;
    logic [63:0] m_q[$];

    task automatic model_reset();
        m_run  = 0;
        m_fin  = 0;
        m_vout = 0;
        m_rout = '0;
        m_n    = 0;
        m_acc  = 0;
        m_sent = 0;
        m_q.delete();
    endtask

    function automatic bit model_ready();
        return m_run && (m_q.size() < DEPTH) && (m_acc < m_n);
    endfunction

    // Advances the model across one rising edge using the current inputs.
    task automatic model_step();
        bit rdy;
        bit do_pop;
        rdy = model_ready();
        if (reset_from_control) begin
            model_reset();
            return;
        end
        // A pulse visible now is counted as it leaves, capped at the run length.
        if (m_vout && m_sent < m_n) m_sent++;
        if (m_run) begin
            if (!enable) begin
                m_run  = 0;
                m_vout = 0;
                m_q.delete();
            end else begin
                do_pop = (m_q.size() > 0) && !fifo_almost_full;
                if (m_vout && m_sent == m_n) begin
                    m_run = 0;
                    m_fin = 1;
                end
                if (do_pop) begin
                    m_rout = m_q.pop_front();
                    m_vout = 1;
                end else begin
                    m_vout = 0;
                end
                if (in_valid && rdy) begin
                    m_q.push_back(in_data);
                    m_acc++;
                end
            end
        end else if (m_fin) begin
            m_vout = 0;
            if (!enable) m_fin = 0;
        end else begin
            m_vout = 0;
            if (enable) begin
                m_n    = n_samples;
                m_acc  = 0;
                m_sent = 0;
                if (n_samples != 0) m_run = 1;
                else                m_fin = 1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            check("reset in_ready", in_ready, 0);
            check("reset result", result_64_bit, 0);
            check("reset valid", result_64_bit_valid, 0);
            check("reset finalizado", calculo_finalizado, 0);
            check("reset sample_count", sample_count, 0);
            model_reset();
        end else begin
            check("model in_ready", in_ready, model_ready());
            check("model valid", result_64_bit_valid, m_vout);
            check("model result", result_64_bit, m_rout);
            check("model finalizado", calculo_finalizado, m_fin);
            check("model sample_count", sample_count, m_sent);
            model_step();
        end
    end

    // ---------------- stimulus helpers ----------------
    int          word;
    int          word_max;
    logic [63:0] got[$];
    bit          s_xfer, s_pulse;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers words 1..word_max in order, logs pulses, advances one cycle.
    task automatic step();
        in_valid = (word <= word_max);
        in_data  = DATA_W'(word);
        s_xfer   = in_valid && in_ready;
        s_pulse  = result_64_bit_valid;
        if (s_pulse) got.push_back(result_64_bit);
        if (s_xfer) word++;
        tick();
    endtask

    task automatic begin_run(input int n, input int wmax);
        got.delete();
        word      = 1;
        word_max  = wmax;
        n_samples = n;
        enable    = 1;
        in_valid  = 0;
        tick();
    endtask

    task automatic check_sequence(input string name, input int n);
        check({name, " pulses"}, got.size(), n);
        for (int i = 0; i < got.size() && i < n; i++) check({name, " data"}, got[i], i + 1);
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_basic();
        int c_xfer = -1, c_pulse = -1, c_last = -1, c_done = -1;
        fifo_almost_full = 0;
        begin_run(4, 4);
        for (int c = 0; c < 20; c++) begin
            if (calculo_finalizado && c_done < 0) c_done = c;
            step();
            if (s_xfer && c_xfer < 0) c_xfer = c;
            if (s_pulse) begin
                if (c_pulse < 0) c_pulse = c;
                c_last = c;
            end
        end
        check_sequence("basic", 4);
        check("basic latency", c_pulse - c_xfer, 2);
        check("basic done delay", c_done - c_last, 1);
        check("basic sample_count", sample_count, 4);
        enable = 0;
        tick();
    endtask

    task automatic test_backpressure();
        fifo_almost_full = 1;
        begin_run(12, 12);
        repeat (20) step();
        check("bp accepted while stalled", word - 1, 8);
        check("bp in_ready stalled", in_ready, 0);
        check("bp no pulse stalled", got.size(), 0);
        fifo_almost_full = 0;
        repeat (40) step();
        check_sequence("bp", 12);
        check("bp sample_count", sample_count, 12);
        check("bp finalizado", calculo_finalizado, 1);
        enable = 0;
        tick();
    endtask

    task automatic test_zero();
        begin_run(0, 0);
        check("zero finalizado", calculo_finalizado, 1);
        check("zero sample_count", sample_count, 0);
        repeat (5) step();
        check("zero pulses", got.size(), 0);
        enable = 0;
        tick();
        check("zero back to idle", calculo_finalizado, 0);
    endtask

    task automatic test_abort();
        fifo_almost_full = 0;
        begin_run(10, 10);
        for (int c = 0; c < 40; c++) begin
            if (result_64_bit_valid && got.size() == 2) enable = 0;
            step();
            if (!enable) break;
        end
        repeat (10) step();
        check_sequence("abort", 3);
        check("abort sample_count", sample_count, 3);
        check("abort in_ready", in_ready, 0);
        check("abort finalizado", calculo_finalizado, 0);
        begin_run(2, 2);
        check("restart sample_count", sample_count, 0);
        repeat (15) step();
        check_sequence("restart", 2);
        check("restart sample_count end", sample_count, 2);
        check("restart finalizado", calculo_finalizado, 1);
        enable = 0;
        tick();
    endtask

    task automatic test_ctrl_clear();
        fifo_almost_full = 1;
        begin_run(20, 5);
        repeat (8) step();
        check("clear setup occupancy", dut.u_fifo.count_q, 5);
        // Clear coincides with an accepted word, a possible pop and enable=1.
        reset_from_control = 1;
        fifo_almost_full   = 0;
        word_max           = 20;
        step();
        reset_from_control = 0;
        check("clear in_ready", in_ready, 0);
        check("clear result", result_64_bit, 0);
        check("clear valid", result_64_bit_valid, 0);
        check("clear finalizado", calculo_finalizado, 0);
        check("clear sample_count", sample_count, 0);
        check("clear occupancy", dut.u_fifo.count_q, 0);
        enable = 0;
        tick();
    endtask

    task automatic test_wrap();
        fifo_almost_full = 1;
        begin_run(30, DEPTH - 1);
        repeat (DEPTH + 1) step();
        check("wrap fill occupancy", dut.u_fifo.count_q, DEPTH - 1);
        fifo_almost_full = 0;
        word_max = 30;
        for (int i = 0; i < 6; i++) begin
            step();
            check("wrap steady occupancy", dut.u_fifo.count_q, DEPTH - 1);
            check("wrap full flag", dut.u_fifo.full_o, 0);
        end
        repeat (60) step();
        check_sequence("wrap", 30);
        check("wrap sample_count", sample_count, 30);
        enable = 0;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 4000; c++) begin
            if (calculo_finalizado) enable = ($urandom_range(0, 99) < 60);
            else if (enable)        enable = ($urandom_range(0, 99) >= 2);
            else                    enable = ($urandom_range(0, 99) < 50);
            if ($urandom_range(0, 9) == 0) fifo_almost_full = ~fifo_almost_full;
            n_samples          = $urandom_range(0, 20);
            reset_from_control = ($urandom_range(0, 299) == 0);
            in_valid           = ($urandom_range(0, 99) < 70);
            in_data            = {$urandom, $urandom};
            tick();
        end
        reset_from_control = 0;
        enable             = 0;
        in_valid           = 0;
        repeat (2) tick();
    endtask

    initial begin
        reset_n            = 1;
        enable             = 0;
        reset_from_control = 0;
        n_samples          = 0;
        in_data            = '0;
        in_valid           = 0;
        fifo_almost_full   = 0;
        #2 reset_n = 0;
        repeat (3) tick();
        reset_n = 1;
        tick();
        test_basic();
        test_backpressure();
        test_zero();
        test_abort();
        test_ctrl_clear();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
